// File: rtl/ex_mul_div_unit.sv
// rtl/ex_mul_div_unit.sv - iterative MIPS HI/LO multiply/divide unit; divider built only when MDU_DIV_EN is defined
module ex_mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic [31:0] regA,
  input  logic [31:0] regB,
  output logic        stall,
  output logic        busy,
  output logic [31:0] mf_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        sgn_q, sgn_d, sa_q, sa_d, sb_q, sb_d;

  logic        is_r, is_mul, is_div, is_mt, is_mf, hilo_op, start, sgn_op;
  logic [32:0] mul_sum;
  logic [63:0] mul_step, step, prod;

  assign is_r   = (opcode == 6'h00);
  assign is_mul = is_r && (func == F_MULT || func == F_MULTU);
  assign is_mt  = is_r && (func == F_MTHI || func == F_MTLO);
  assign is_mf  = is_r && (func == F_MFHI || func == F_MFLO);
`ifdef MDU_DIV_EN
  assign is_div = is_r && (func == F_DIV || func == F_DIVU);
`else
  assign is_div = 1'b0;
`endif
  assign hilo_op = is_mul | is_div | is_mt | is_mf;
  assign start   = (state_q == S_IDLE) && (is_mul || is_div);
  assign sgn_op  = (func == F_MULT) || (func == F_DIV);

  assign busy    = (state_q != S_IDLE);
  assign stall   = busy & hilo_op;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign mf_data = (func == F_MFHI) ? hi_q : lo_q;

  // Right-shifting shift-add: add multiplicand at bit 32, then shift the whole accumulator down
  assign mul_sum  = {1'b0, acc_q[63:32]} + (b_q[cnt_q] ? {1'b0, a_q} : 33'd0);
  assign mul_step = {mul_sum, acc_q[31:1]};
  assign prod     = (sgn_q && (sa_q ^ sb_q)) ? -acc_q : acc_q;

`ifdef MDU_DIV_EN
  logic        div_q, div_d;
  logic [32:0] rem_sh, rem_diff;
  logic [63:0] div_step;
  logic [31:0] quo, rem, a_raw;

  // Restoring division: remainder lives in acc[63:32], quotient bits shift into acc[31:0]
  assign rem_sh   = {acc_q[63:32], a_q[5'd31 - cnt_q]};
  assign rem_diff = rem_sh - {1'b0, b_q};
  assign div_step = rem_diff[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                                 : {rem_diff[31:0], acc_q[30:0], 1'b1};
  assign step     = div_q ? div_step : mul_step;
  assign quo      = (sgn_q && (sa_q ^ sb_q)) ? -acc_q[31:0] : acc_q[31:0];
  assign rem      = (sgn_q && sa_q) ? -acc_q[63:32] : acc_q[63:32];
  // Re-negating the magnitude recovers the original dividend, including 32'h80000000
  assign a_raw    = (sgn_q && sa_q) ? -a_q : a_q;
`else
  assign step     = mul_step;
`endif

  // Next state: issue latches operands, BUSY iterates 32 times, FIX applies signs and writes HI/LO
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDU_DIV_EN
    div_d   = div_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_BUSY;
          cnt_d   = 5'd0;
          acc_d   = 64'd0;
          sgn_d   = sgn_op;
          sa_d    = regA[31];
          sb_d    = regB[31];
          a_d     = (sgn_op && regA[31]) ? -regA : regA;
          b_d     = (sgn_op && regB[31]) ? -regB : regB;
`ifdef MDU_DIV_EN
          div_d   = is_div;
`endif
        end else if (is_mt) begin
          if (func == F_MTHI) hi_d = regA;
          else                lo_d = regA;
        end
      end
      S_BUSY: begin
        acc_d = step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
`ifdef MDU_DIV_EN
        if (div_q) begin
          if (b_q == 32'd0) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = a_raw;
          end else begin
            lo_d = quo;
            hi_d = rem;
          end
        end else
`endif
        begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath and architectural HI/LO registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 5'd0;
      acc_q <= 64'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      sgn_q <= 1'b0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
`ifdef MDU_DIV_EN
      div_q <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sgn_q <= sgn_d;
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
`ifdef MDU_DIV_EN
      div_q <= div_d;
`endif
    end
  end

endmodule
